// File: rtl/mc_control_fsm_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle ARM-subset controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: state enum, opcode/cmd codes, ALU op, result mux and ALU B-source selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_ctrl_if: instruction fields and memory ready into the controller, datapath controls out.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the unified memory stalls the controller.
// Modports: master = controller (drives controls), slave = datapath/IR/memory side.
interface mc_ctrl_if;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       reg_write;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       illegal;

    modport master (
        input  op, funct, rd, cond_ex, mem_ready,
        output pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, flag_w, reg_write,
               imm_src, reg_src, illegal
    );

    modport slave (
        output op, funct, rd, cond_ex, mem_ready,
        input  pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, flag_w, reg_write,
               imm_src, reg_src, illegal
    );

endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// mc_alu_decoder: maps state and data-processing cmd/S to alu_control, flag_w and an unsupported-cmd flag.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of its inputs.
// Ports: state, cmd, s, cond_ex in; alu_control, flag_w, illegal_cmd out.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] cmd,
    input  logic       s,
    input  logic       cond_ex,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       illegal_cmd
);

    logic [1:0] cmd_alu;
    logic       cmd_arith;
    logic       in_exe;

    always_comb begin
        cmd_alu     = ALU_ADD;
        cmd_arith   = 1'b0;
        illegal_cmd = 1'b0;
        case (cmd)
            CMD_ADD: begin cmd_alu = ALU_ADD; cmd_arith = 1'b1; end
            CMD_SUB: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; end
            CMD_AND: cmd_alu = ALU_AND;
            CMD_ORR: cmd_alu = ALU_ORR;
            // CMP only makes sense when it sets flags
            CMD_CMP: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; illegal_cmd = ~s; end
            default: illegal_cmd = 1'b1;
        endcase
    end

    assign in_exe = (state == S_EXER) || (state == S_EXEI);

    // Fetch/decode/address/branch all use the adder
    assign alu_control = in_exe ? cmd_alu : ALU_ADD;
    // NZ written on any S-form op; CV only by arithmetic
    assign flag_w      = (in_exe && s && cond_ex) ? {1'b1, cmd_arith} : 2'b00;

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle fetch/decode/execute/memory/writeback sequencer for the ARM-subset datapath.
// Latency: DP 4, CMP 3, LDR 5, STR 4, B 3, illegal 2 cycles with mem_ready high; +1 per mem_ready=0 wait cycle.
// Backpressure: holds in FETCH, MEMRD and MEMWR until mem_ready; a cond-failed store skips the access.
// Ports: clk, rst_n (synchronous, active low); bus (mc_ctrl_if.master) carries IR fields in and controls out.
// Optional: define MC_PERF_CNT_EN to add instr_retired[ADDR_W-1:0], counting every return to FETCH.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_ctrl_if.master         bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [ADDR_W-1:0] instr_retired
`endif
);

    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("ADDR_W must be at least 1");
    end

    state_t     state;
    state_t     state_nxt;

    logic       i_bit;
    logic       l_s_bit;
    logic [3:0] cmd;
    logic       illegal_cmd;
    logic [1:0] alu_ctl;
    logic [1:0] flag_w_raw;

    logic       next_pc;
    logic       ir_wr;
    logic       mreq;
    logic       mwr;
    logic       adr;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic       reg_w;
    logic       is_branch;
    logic       dec_illegal;
    logic       rd_is_pc;
    logic       pcs;

    assign i_bit   = bus.funct[5];
    assign cmd     = bus.funct[4:1];
    assign l_s_bit = bus.funct[0];

    mc_alu_decoder u_alu_dec (
        .state       (state),
        .cmd         (cmd),
        .s           (l_s_bit),
        .cond_ex     (bus.cond_ex),
        .alu_control (alu_ctl),
        .flag_w      (flag_w_raw),
        .illegal_cmd (illegal_cmd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_MEM: state_nxt = S_MEMADR;
                    OP_DP:  state_nxt = illegal_cmd ? S_FETCH : (i_bit ? S_EXEI : S_EXER);
                    OP_BR:  state_nxt = S_BRANCH;
                    OP_ILL: state_nxt = S_FETCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = l_s_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            // A cond-failed store never issues, so it does not wait for memory
            S_MEMWR:  if (!bus.cond_ex || bus.mem_ready) state_nxt = S_FETCH;
            S_EXER,
            S_EXEI:   state_nxt = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH: state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        next_pc     = 1'b0;
        ir_wr       = 1'b0;
        mreq        = 1'b0;
        mwr         = 1'b0;
        adr         = 1'b0;
        res         = RES_ALUOUT;
        srca        = 1'b0;
        srcb        = SRCB_REG;
        reg_w       = 1'b0;
        is_branch   = 1'b0;
        dec_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                mreq    = 1'b1;
                srca    = 1'b1;
                srcb    = SRCB_FOUR;
                res     = RES_ALURES;
                ir_wr   = bus.mem_ready;
                next_pc = bus.mem_ready;
            end
            S_DECODE: begin
                // Second PC+4 yields PC+8 for the register read of R15
                srca        = 1'b1;
                srcb        = SRCB_FOUR;
                res         = RES_ALURES;
                dec_illegal = (bus.op == OP_ILL) || ((bus.op == OP_DP) && illegal_cmd);
            end
            S_MEMADR: srcb = SRCB_IMM;
            S_MEMRD: begin
                mreq = 1'b1;
                adr  = 1'b1;
            end
            S_MEMWR: begin
                adr  = 1'b1;
                mreq = bus.cond_ex;
                mwr  = bus.cond_ex;
            end
            S_MEMWB: begin
                res   = RES_DATA;
                reg_w = 1'b1;
            end
            S_EXER:  srcb = SRCB_REG;
            S_EXEI:  srcb = SRCB_IMM;
            S_ALUWB: begin
                res   = RES_ALUOUT;
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                srcb      = SRCB_IMM;
                res       = RES_ALURES;
                is_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // A writeback to R15 becomes a PC load instead of a register write
    assign rd_is_pc = (bus.rd == 4'd15);
    assign pcs      = (rd_is_pc && reg_w) || is_branch;

    assign bus.pc_write    = rst_n & (next_pc | (pcs & bus.cond_ex));
    assign bus.reg_write   = rst_n & reg_w & bus.cond_ex & ~rd_is_pc;
    assign bus.ir_write    = rst_n & ir_wr;
    assign bus.mem_req     = rst_n & mreq;
    assign bus.mem_write   = rst_n & mwr;
    assign bus.flag_w      = rst_n ? flag_w_raw : 2'b00;
    assign bus.illegal     = rst_n & dec_illegal;
    assign bus.adr_src     = adr;
    assign bus.result_src  = res;
    assign bus.alu_src_a   = srca;
    assign bus.alu_src_b   = srcb;
    assign bus.alu_control = alu_ctl;
    assign bus.imm_src     = bus.op;
    assign bus.reg_src     = {(bus.op == OP_MEM) && !l_s_bit, bus.op == OP_BR};

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_retired <= '0;
        end else if ((state != S_FETCH) && (state_nxt == S_FETCH)) begin
            instr_retired <= instr_retired + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main sequencing controller for the multicycle ARM-subset datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath write enable and mux select, and it forms the final PC write as NextPC or (PCS and CondEx), with PCS computed internally as (Rd==15 & RegW) | Branch. It sits between the instruction register and the shared datapath, and waits on a ready handshake from the unified instruction/data memory.

Parameters:
- ADDR_W, 32, width of the optional retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- funct  in  6  instr[25:20]: [5] I, [4:1] cmd, [0] S (for memory ops: L).
- rd  in  4  instr[15:12].
- cond_ex  in  1  condition-check result, valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  0: PC, 1: ALUOut.
- mem_req  out  1  memory access request.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register enable.
- result_src  out  2  00: ALUOut, 01: Data, 10: ALUResult.
- alu_src_a  out  1  0: Rn, 1: PC.
- alu_src_b  out  2  00: Rm, 01: Imm, 10: const 4.
- alu_control  out  2  00 add, 01 sub, 10 and, 11 orr.
- flag_w  out  2  [1] NZ write, [0] CV write.
- reg_write  out  1  register file write.
- imm_src  out  2  equals op.
- reg_src  out  2  [1]: op==01 & ~L, [0]: op==10.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH. Encoding is 4-bit binary. Reset state is FETCH.
- While rst_n=0: next state is FETCH, and pc_write, mem_write, reg_write, ir_write, mem_req, flag_w and illegal are all 0.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_control=00, result_src=10.
  - ir_write and pc_write assert only in the cycle mem_ready=1. That cycle moves to DECODE.
  - Otherwise the FSM stays in FETCH with all enables 0.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10 (computes PC+8). Next state by op:
  - 01 → MEMADR.
  - 00 with I=0 → EXER; 00 with I=1 → EXEI.
  - 10 → BRANCH.
  - 11, or an unsupported cmd → illegal=1 for one cycle, then FETCH.
- Supported cmds: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP. CMP requires S=1; with S=0 it is illegal.
- alu_control by cmd: ADD→00, SUB/CMP→01, AND→10, ORR→11. Memory and branch ops use 00.
- flag_w:
  - In EXER and EXEI: flag_w=S ? {1, cmd is ADD/SUB/CMP} : 00, gated by cond_ex.
  - flag_w is 0 in every other state.
- MEMADR: alu_src_a=0, alu_src_b=01. Next is MEMRD if L=1, else MEMWR.
- MEMRD: mem_req=1, adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWR: mem_req=1, adr_src=1, mem_write=cond_ex. Holds until mem_ready=1, then goes to FETCH.
  - mem_write stays asserted for every cycle of the hold.
  - If cond_ex=0: no access is issued (mem_req=0) and the FSM goes straight to FETCH.
- MEMWB: result_src=01. Then FETCH.
- EXER: alu_src_a=0, alu_src_b=00. Next is ALUWB, or FETCH for CMP.
- EXEI: alu_src_a=0, alu_src_b=01. Next is ALUWB, or FETCH for CMP.
- ALUWB: result_src=00. Then FETCH.
- BRANCH: alu_src_a=0 (Rn path carries PC+8), alu_src_b=01, result_src=10. Then FETCH.
- Writeback in MEMWB, ALUWB and BRANCH:
  - reg_w=1 in MEMWB and ALUWB.
  - reg_write=reg_w & cond_ex & (rd!=15).
  - pc_write=((rd==15 & reg_w) | state==BRANCH) & cond_ex.
  - rd==15 therefore redirects the PC instead of writing R15.
- Latency with mem_ready tied high:
  - Data-processing: 4 cycles; CMP: 3 cycles.
  - LDR: 5 cycles; STR: 4 cycles.
  - Branch: 3 cycles; illegal: 2 cycles.
- Memory-wait states add one cycle per mem_ready=0 cycle.
- rst_n low in any state (including mid-wait): FETCH on the next edge, with no write enable asserted in that cycle.
- All outputs are combinational from the state register and the instruction fields. There are no output registers.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - Adds output instr_retired[ADDR_W-1:0].
  - Cleared by reset.
  - Increments on every transition into FETCH from any non-FETCH state, including illegal and cond-fail instructions.
  - Wraps from all-ones to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum;
  - OP_DP/OP_MEM/OP_BR codes;
  - CMD_* codes;
  - ALU_ADD/SUB/AND/ORR;
  - RES_ALUOUT/DATA/ALURES;
  - SRCB_REG/IMM/FOUR.
- One sub-module, mc_alu_decoder, maps (state, cmd, S, cond_ex) to alu_control, flag_w and the illegal-cmd flag.
- PCS and the writeback gating stay in the top module.

Test Plan:
- ADD R1 (op=00, I=0, cmd=0100, S=0, rd=1), cond_ex=1, mem_ready=1 → FETCH, DECODE, EXER, ALUWB. reg_write=1 only in ALUWB; pc_write=1 only in FETCH.
- LDR rd=15, mem_ready low for 2 cycles in MEMRD → 7 cycles total. MEMWB gives reg_write=0, pc_write=1.
- Branch with cond_ex=0 → BRANCH state asserts pc_write=0 and reg_write=0, then returns to FETCH.
- STR with cond_ex=0 → mem_req=0 and mem_write=0 in MEMWR, then FETCH the next cycle.
- op=11 → illegal=1 in DECODE for exactly one cycle, no enables asserted, then FETCH. CMP with S=0 behaves the same.
- rst_n low during MEMRD wait → FETCH next cycle with all enables 0. With MC_PERF_CNT_EN: counter reads 0 and wraps at 2^ADDR_W retirements.
